ext_intr_requester: RTL

- Interrupt-initiator front end for the MicroBlaze subsystem.
- Conditions a raw push-button through a synchroniser and debouncer, and queues debounced press events in a saturating pending counter.
- Drives a level interrupt request toward the processor-side interrupt controller until the processor acknowledges it.
- Sits between the board button and the processor wrapper's external interrupt input; the processor's acknowledge output closes the handshake.

---
 rtl/ext_intr_requester.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ext_intr_requester.sv
// Push-button interrupt initiator: synchronise and debounce the button, count presses,
// and hold a level request toward the interrupt controller until it is acknowledged.
module ext_intr_requester #(
  parameter int unsigned DEBOUNCE_CYCLES    = 1_000_000,
  parameter int unsigned MAX_PENDING        = 15,
  parameter int unsigned PEND_W             = 4,
  parameter int unsigned ACK_TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned GAP_CYCLES         = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              button_in,
  input  logic              intr_ack,
  input  logic              clear_overflow,
  output logic              intr_req,
  output logic [PEND_W-1:0] pending_cnt,
  output logic              overflow,
  output logic              timeout,
  output logic              button_db
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 2)    ? $clog2(DEBOUNCE_CYCLES)    : 1;
  localparam int unsigned TO_W  = (ACK_TIMEOUT_CYCLES > 2) ? $clog2(ACK_TIMEOUT_CYCLES) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 2)         ? $clog2(GAP_CYCLES)         : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK_LOW, GAP} state_e;

  state_e             state_q, state_d;
  logic [1:0]         sync_q, sync_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic               button_db_q, button_db_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               overflow_q, overflow_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               intr_req_q, intr_req_d;
  logic               timeout_q, timeout_d;
  logic               sync_btn, press, consume, ovf_set;

  assign sync_btn = sync_q[1];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sync_d      = {sync_q[0], button_in};
    db_cnt_d    = '0;
    button_db_d = button_db_q;
    if (sync_btn != button_db_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        button_db_d = sync_btn;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Only the debounced rising edge is an event; release is ignored.
  assign press = button_db_d & ~button_db_q;

  always_comb begin
    state_d    = state_q;
    to_cnt_d   = '0;
    gap_cnt_d  = '0;
    timeout_d  = 1'b0;
    consume    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q != '0) state_d = REQ;
      end
      REQ: begin
        // Acknowledge takes priority over a timeout landing in the same cycle.
        if (intr_ack) begin
          consume = 1'b1;
          state_d = WAIT_ACK_LOW;
        end else if (to_cnt_q == TO_W'(ACK_TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = GAP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      WAIT_ACK_LOW: begin
        if (!intr_ack) state_d = GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    intr_req_d = (state_d == REQ);
  end

  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (press && !consume) begin
      if (pend_q == PEND_W'(MAX_PENDING)) ovf_set = 1'b1;
      else                                pend_d  = pend_q + PEND_W'(1);
    end else if (consume && !press) begin
      pend_d = pend_q - PEND_W'(1);
    end
    if (ovf_set)             overflow_d = 1'b1;
    else if (clear_overflow) overflow_d = 1'b0;
    else                     overflow_d = overflow_q;
  end

  // NOTE: sequential state uses non-blocking assignments only; every flop here is
  // control state, so all of them take the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      db_cnt_q    <= '0;
      button_db_q <= 1'b0;
      pend_q      <= '0;
      overflow_q  <= 1'b0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      intr_req_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      db_cnt_q    <= db_cnt_d;
      button_db_q <= button_db_d;
      pend_q      <= pend_d;
      overflow_q  <= overflow_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      intr_req_q  <= intr_req_d;
      timeout_q   <= timeout_d;
    end
  end

  assign intr_req    = intr_req_q;
  assign pending_cnt = pend_q;
  assign overflow    = overflow_q;
  assign timeout     = timeout_q;
  assign button_db   = button_db_q;

endmodule
